// File: rtl/text_fetch_sequencer_if.sv
// ============================================================================
// Module      : text_fetch_sequencer_if
// Description : Pixel-in, text RAM / font ROM and colour-stage signals of the
//               text fetch sequencer, grouped with master/slave modports.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface text_fetch_sequencer_if;
    logic        pix_valid;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic        frame_start;
    logic        cursor_en;
    logic [6:0]  cursor_col;
    logic [4:0]  cursor_row;
    logic [11:0] text_addr;
    logic [15:0] text_data;
    logic [11:0] font_addr;
    logic [7:0]  font_data;
    logic        valid_out;
    logic [7:0]  font_line_data;
    logic [2:0]  char_pix_x;
    logic [7:0]  bg_fg_index;

    modport master (
        output pix_valid, pix_x, pix_y, frame_start,
        output cursor_en, cursor_col, cursor_row,
        output text_data, font_data,
        input  text_addr, font_addr,
        input  valid_out, font_line_data, char_pix_x, bg_fg_index
    );

    modport slave (
        input  pix_valid, pix_x, pix_y, frame_start,
        input  cursor_en, cursor_col, cursor_row,
        input  text_data, font_data,
        output text_addr, font_addr,
        output valid_out, font_line_data, char_pix_x, bg_fg_index
    );
endinterface

`default_nettype wire

// File: rtl/text_fetch_sequencer.sv
// ============================================================================
// Module      : text_fetch_sequencer
// Description : Five-stage text-mode fetch pipeline: pixel -> text RAM ->
//               font ROM -> aligned glyph line with blinking block cursor.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module text_fetch_sequencer #(
    parameter int COLS = 80,
    parameter int ROWS = 30
) (
    input  wire                     clk,
    input  wire                     rst,
    text_fetch_sequencer_if.slave   bus
);

    localparam logic [7:0]  C_COLS   = 8'(COLS);
    localparam logic [5:0]  C_ROWS   = 6'(ROWS);
    localparam logic [11:0] C_COLS_W = 12'(COLS);

    // S0: pixel decode
    logic [6:0] w_char_col;
    logic [4:0] w_char_row;
    logic [3:0] w_glyph_row;
    logic       w_in_range;
    logic       w_cursor_hit;
    logic       w_unused;

    assign w_char_col  = bus.pix_x[9:3];
    assign w_char_row  = bus.pix_y[8:4];
    assign w_glyph_row = bus.pix_y[3:0];
    assign w_unused    = bus.pix_y[9];

    assign w_in_range = bus.pix_valid
                     && ({1'b0, w_char_col} < C_COLS)
                     && ({1'b0, w_char_row} < C_ROWS);

    // Cursor is an underline block on the bottom two glyph rows of its cell
    assign w_cursor_hit = w_in_range && bus.cursor_en
                       && (w_char_col == bus.cursor_col)
                       && (w_char_row == bus.cursor_row)
                       && (w_glyph_row >= 4'd14);

    // Pipeline state
    logic [5:0]  frame_cnt_q,  frame_cnt_d;
    logic [11:0] text_addr_q,  text_addr_d;
    logic        s1_valid_q,   s1_valid_d;
    logic [2:0]  s1_pix_x_q,   s1_pix_x_d;
    logic [3:0]  s1_glyph_q,   s1_glyph_d;
    logic        s1_hit_q,     s1_hit_d;
    logic        s2_valid_q,   s2_valid_d;
    logic [2:0]  s2_pix_x_q,   s2_pix_x_d;
    logic [3:0]  s2_glyph_q,   s2_glyph_d;
    logic        s2_hit_q,     s2_hit_d;
    logic [11:0] font_addr_q,  font_addr_d;
    logic        s3_valid_q,   s3_valid_d;
    logic [2:0]  s3_pix_x_q,   s3_pix_x_d;
    logic        s3_hit_q,     s3_hit_d;
    logic [7:0]  s3_attr_q,    s3_attr_d;
    logic        s4_valid_q,   s4_valid_d;
    logic [2:0]  s4_pix_x_q,   s4_pix_x_d;
    logic        s4_hit_q,     s4_hit_d;
    logic [7:0]  s4_attr_q,    s4_attr_d;
    logic        valid_out_q,  valid_out_d;
    logic [7:0]  font_line_q,  font_line_d;
    logic [2:0]  char_pix_x_q, char_pix_x_d;
    logic [7:0]  bg_fg_q,      bg_fg_d;

    always_comb begin
        frame_cnt_d = bus.frame_start ? frame_cnt_q + 6'd1 : frame_cnt_q;

        // S1: address is computed even for invalid pixels; the read is harmless
        text_addr_d = ({7'd0, w_char_row} * C_COLS_W) + {5'd0, w_char_col};
        s1_valid_d  = w_in_range;
        s1_pix_x_d  = bus.pix_x[2:0];
        s1_glyph_d  = w_glyph_row;
        s1_hit_d    = w_cursor_hit;

        // S2: text RAM read in flight
        s2_valid_d  = s1_valid_q;
        s2_pix_x_d  = s1_pix_x_q;
        s2_glyph_d  = s1_glyph_q;
        s2_hit_d    = s1_hit_q;

        // S3: character code indexes the font ROM
        font_addr_d = {bus.text_data[7:0], s2_glyph_q};
        s3_valid_d  = s2_valid_q;
        s3_pix_x_d  = s2_pix_x_q;
        s3_hit_d    = s2_hit_q;
        s3_attr_d   = bus.text_data[15:8];

        // S4: font ROM read in flight
        s4_valid_d  = s3_valid_q;
        s4_pix_x_d  = s3_pix_x_q;
        s4_hit_d    = s3_hit_q;
        s4_attr_d   = s3_attr_q;

        // S5: invalid pixels present an all-zero bundle
        valid_out_d  = s4_valid_q;
        font_line_d  = 8'h00;
        char_pix_x_d = 3'd0;
        bg_fg_d      = 8'h00;
        if (s4_valid_q) begin
            font_line_d  = (s4_hit_q && frame_cnt_q[5]) ? 8'hFF : bus.font_data;
            char_pix_x_d = s4_pix_x_q;
            bg_fg_d      = s4_attr_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt_q  <= 6'd0;
            text_addr_q  <= 12'd0;
            s1_valid_q   <= 1'b0;
            s1_pix_x_q   <= 3'd0;
            s1_glyph_q   <= 4'd0;
            s1_hit_q     <= 1'b0;
            s2_valid_q   <= 1'b0;
            s2_pix_x_q   <= 3'd0;
            s2_glyph_q   <= 4'd0;
            s2_hit_q     <= 1'b0;
            font_addr_q  <= 12'd0;
            s3_valid_q   <= 1'b0;
            s3_pix_x_q   <= 3'd0;
            s3_hit_q     <= 1'b0;
            s3_attr_q    <= 8'h00;
            s4_valid_q   <= 1'b0;
            s4_pix_x_q   <= 3'd0;
            s4_hit_q     <= 1'b0;
            s4_attr_q    <= 8'h00;
            valid_out_q  <= 1'b0;
            font_line_q  <= 8'h00;
            char_pix_x_q <= 3'd0;
            bg_fg_q      <= 8'h00;
        end else begin
            frame_cnt_q  <= frame_cnt_d;
            text_addr_q  <= text_addr_d;
            s1_valid_q   <= s1_valid_d;
            s1_pix_x_q   <= s1_pix_x_d;
            s1_glyph_q   <= s1_glyph_d;
            s1_hit_q     <= s1_hit_d;
            s2_valid_q   <= s2_valid_d;
            s2_pix_x_q   <= s2_pix_x_d;
            s2_glyph_q   <= s2_glyph_d;
            s2_hit_q     <= s2_hit_d;
            font_addr_q  <= font_addr_d;
            s3_valid_q   <= s3_valid_d;
            s3_pix_x_q   <= s3_pix_x_d;
            s3_hit_q     <= s3_hit_d;
            s3_attr_q    <= s3_attr_d;
            s4_valid_q   <= s4_valid_d;
            s4_pix_x_q   <= s4_pix_x_d;
            s4_hit_q     <= s4_hit_d;
            s4_attr_q    <= s4_attr_d;
            valid_out_q  <= valid_out_d;
            font_line_q  <= font_line_d;
            char_pix_x_q <= char_pix_x_d;
            bg_fg_q      <= bg_fg_d;
        end
    end

    assign bus.text_addr      = text_addr_q;
    assign bus.font_addr      = font_addr_q;
    assign bus.valid_out      = valid_out_q;
    assign bus.font_line_data = font_line_q;
    assign bus.char_pix_x     = char_pix_x_q;
    assign bus.bg_fg_index    = bg_fg_q;

endmodule

`default_nettype wire

// File: tb/tb_text_fetch_sequencer.sv
// ============================================================================
// Module      : tb_text_fetch_sequencer
// Description : Directed bench for text_fetch_sequencer with text RAM / font
//               ROM models and hand-computed expected values.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_text_fetch_sequencer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    text_fetch_sequencer_if bus ();

    text_fetch_sequencer #(.COLS(80), .ROWS(30)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [15:0] text_ram [4096];
    logic [7:0]  font_rom [4096];

    // Synchronous-read memories: data one cycle after address
    always @(posedge clk) begin
        bus.text_data <= text_ram[bus.text_addr];
        bus.font_data <= font_rom[bus.font_addr];
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input int x, input int y);
        bus.pix_valid = v;
        bus.pix_x     = 10'(x);
        bus.pix_y     = 10'(y);
    endtask

    task automatic negs(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, 32'(bus.valid_out), 0);
        chk({tag, "_line"},  32'(bus.font_line_data), 0);
        chk({tag, "_cpx"},   32'(bus.char_pix_x), 0);
        chk({tag, "_attr"},  32'(bus.bg_fg_index), 0);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            text_ram[i] = 16'(i * 16'h0101);
            font_rom[i] = 8'(i * 5 + 3);
        end
        text_ram[0]     = 16'h1F41;  font_rom[12'h410] = 8'h18;
        text_ram[1]     = 16'h2E42;  font_rom[12'h420] = 8'h3C;
        text_ram[2399]  = 16'hA563;  font_rom[12'h63F] = 8'h5A;
        text_ram[82]    = 16'h7053;  font_rom[12'h53D] = 8'h81;
        font_rom[12'h53E] = 8'h42;   font_rom[12'h53F] = 8'h99;
        text_ram[83]    = 16'h6054;  font_rom[12'h54E] = 8'h24;

        rst = 1'b1;
        drive(1'b0, 0, 0);
        bus.frame_start = 1'b0;
        bus.cursor_en   = 1'b0;
        bus.cursor_col  = 7'd0;
        bus.cursor_row  = 5'd0;
        negs(3);

        // Reset state
        chk_zero("rst");
        chk("rst_taddr", 32'(bus.text_addr), 0);
        chk("rst_faddr", 32'(bus.font_addr), 0);
        rst = 1'b0;

        // Pixel (0,0): exact five-cycle latency
        negs(1); drive(1'b1, 0, 0);
        negs(1); drive(1'b0, 0, 0);
        chk("p00_taddr", 32'(bus.text_addr), 0);
        negs(2);
        chk("p00_faddr", 32'(bus.font_addr), 32'h410);
        negs(1);
        chk("p00_early", 32'(bus.valid_out), 0);
        negs(1);
        chk("p00_valid", 32'(bus.valid_out), 1);
        chk("p00_line",  32'(bus.font_line_data), 32'h18);
        chk("p00_attr",  32'(bus.bg_fg_index), 32'h1F);
        chk("p00_cpx",   32'(bus.char_pix_x), 0);
        negs(1);
        chk("p00_late", 32'(bus.valid_out), 0);

        // Last visible pixel (639,479)
        drive(1'b1, 639, 479);
        negs(1); drive(1'b0, 0, 0);
        chk("pmax_taddr", 32'(bus.text_addr), 2399);
        negs(2);
        chk("pmax_faddr", 32'(bus.font_addr), 32'h63F);
        negs(2);
        chk("pmax_valid", 32'(bus.valid_out), 1);
        chk("pmax_cpx",   32'(bus.char_pix_x), 7);
        chk("pmax_line",  32'(bus.font_line_data), 32'h5A);
        chk("pmax_attr",  32'(bus.bg_fg_index), 32'hA5);

        // Continuous scan x=0..15, y=0
        for (int i = 0; i < 21; i++) begin
            negs(1);
            if (i >= 1 && i <= 16)
                chk("scan_taddr", 32'(bus.text_addr), (i - 1) >= 8 ? 1 : 0);
            if (i >= 5) begin
                chk("scan_valid", 32'(bus.valid_out), 1);
                chk("scan_cpx",   32'(bus.char_pix_x), (i - 5) % 8);
                chk("scan_line",  32'(bus.font_line_data), (i - 5) < 8 ? 32'h18 : 32'h3C);
                chk("scan_attr",  32'(bus.bg_fg_index), (i - 5) < 8 ? 32'h1F : 32'h2E);
            end
            if (i < 16) drive(1'b1, i, 0);
            else        drive(1'b0, 0, 0);
        end
        negs(1);
        chk("scan_end", 32'(bus.valid_out), 0);

        // In-range, column out of range, not valid, row out of range
        drive(1'b1, 8, 0);
        negs(1); drive(1'b1, 700, 10);
        negs(1); drive(1'b0, 3, 3);
        negs(1); drive(1'b1, 0, 480);
        negs(1); drive(1'b0, 0, 0);
        negs(1);
        chk("oor_ref_valid", 32'(bus.valid_out), 1);
        chk("oor_ref_line",  32'(bus.font_line_data), 32'h3C);
        negs(1); chk_zero("oor_col");
        negs(1); chk_zero("oor_inv");
        negs(1); chk_zero("oor_row");

        // Cursor at (2,1): 31 frames -> blink off
        bus.cursor_en  = 1'b1;
        bus.cursor_col = 7'd2;
        bus.cursor_row = 5'd1;
        for (int i = 0; i < 31; i++) begin
            negs(1); bus.frame_start = 1'b1;
            negs(1); bus.frame_start = 1'b0;
        end
        negs(1); drive(1'b1, 16, 30);
        negs(1); drive(1'b0, 0, 0);
        negs(4);
        chk("cur31_line", 32'(bus.font_line_data), 32'h42);

        // 32nd frame pulse concurrent with a hit pixel -> blink on
        negs(1); bus.frame_start = 1'b1; drive(1'b1, 16, 30);
        negs(1); bus.frame_start = 1'b0; drive(1'b1, 16, 29);
        negs(1); drive(1'b1, 16, 31);
        negs(1); drive(1'b1, 24, 30);
        negs(1); drive(1'b0, 0, 0);
        negs(1);
        chk("cur_hit14",  32'(bus.font_line_data), 32'hFF);
        chk("cur_attr",   32'(bus.bg_fg_index), 32'h70);
        negs(1);
        chk("cur_row13",  32'(bus.font_line_data), 32'h81);
        negs(1);
        chk("cur_hit15",  32'(bus.font_line_data), 32'hFF);
        negs(1);
        chk("cur_col3",   32'(bus.font_line_data), 32'h24);

        // 64 pulses total -> frame_cnt wraps to 0, blink off
        for (int i = 0; i < 32; i++) begin
            negs(1); bus.frame_start = 1'b1;
            negs(1); bus.frame_start = 1'b0;
        end
        negs(1); drive(1'b1, 16, 30);
        negs(1); drive(1'b0, 0, 0);
        negs(4);
        chk("cur64_valid", 32'(bus.valid_out), 1);
        chk("cur64_line",  32'(bus.font_line_data), 32'h42);
        bus.cursor_en = 1'b0;

        // Reset in the middle of an active scan
        for (int i = 0; i < 7; i++) begin
            negs(1); drive(1'b1, i, 0);
        end
        negs(1);
        chk("mid_pre_valid", 32'(bus.valid_out), 1);
        rst = 1'b1;
        drive(1'b0, 0, 0);
        #1;
        chk_zero("mid_rst");
        chk("mid_taddr", 32'(bus.text_addr), 0);
        chk("mid_faddr", 32'(bus.font_addr), 0);
        negs(1); rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            negs(1);
            chk("post_idle", 32'(bus.valid_out), 0);
        end
        drive(1'b1, 8, 0);
        for (int i = 1; i <= 4; i++) begin
            negs(1);
            drive(1'b0, 0, 0);
            chk("post_wait", 32'(bus.valid_out), 0);
        end
        negs(1);
        chk("post_valid", 32'(bus.valid_out), 1);
        chk("post_cpx",   32'(bus.char_pix_x), 0);
        chk("post_line",  32'(bus.font_line_data), 32'h3C);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
